btb_assoc_pred: RTL and testbench

- Parametrised N-way set-associative branch target buffer with per-entry 2-bit direction counters, tree pseudo-LRU replacement and a sequential flush engine.
- Sits between IF and EX.
- IF presents the fetch PC and receives hit, direction and target in the same cycle.
- EX resolves branches and writes back one update per cycle.
- Replaces the fixed 16-set/4-way allocate-only BTB with one that updates in place, does not duplicate entries, and can be flushed.

---
 rtl/btb_assoc_pred.sv | 208 ++++++++++++++++++++
 tb/tb_btb_assoc_pred.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc_pred.sv
// btb_assoc_pred: N-way set-associative branch target buffer with tree-PLRU replacement,
// in-place update and a one-set-per-cycle flush sweep. Define BTB_DIR_CTR_EN for 2-bit direction counters.
module btb_assoc_pred #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        btb_hit,
  output logic        predict_taken,
  output logic [31:0] predicted_pc,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        flush,
  output logic        busy
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int NODE_W = WAY_W + 1;
  localparam int PLRU_W = NUM_WAYS - 1;
  localparam int TAG_W  = 32 - 2 - IDX_W;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      sweep_q, sweep_d;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
  logic [PLRU_W-1:0]     plru_q  [NUM_SETS];
  logic [PLRU_W-1:0]     plru_d  [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      tag_d   [NUM_SETS][NUM_WAYS];
  logic [31:0]           tgt_q   [NUM_SETS][NUM_WAYS];
  logic [31:0]           tgt_d   [NUM_SETS][NUM_WAYS];
`ifdef BTB_DIR_CTR_EN
  logic [1:0]            ctr_q   [NUM_SETS][NUM_WAYS];
  logic [1:0]            ctr_d   [NUM_SETS][NUM_WAYS];
`endif

  logic [IDX_W-1:0]      rd_set, wr_set;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic                  rd_hit, wr_hit, inv_found;
  logic [WAY_W-1:0]      rd_way, wr_way, inv_way, alloc_way;
  logic                  unused_pc_lsbs;

  // Tree nodes are heap-ordered (root 0, children 2n+1 / 2n+2); a set bit sends the victim right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] tree);
    logic [NUM_WAYS-1:0] bits;
    logic [NODE_W-1:0]   node;
    bits = {1'b0, tree};
    node = '0;
    for (int l = 0; l < WAY_W; l++)
      node = (node << 1) + NODE_W'(1) + NODE_W'(bits[node[WAY_W-1:0]]);
    return WAY_W'(node - NODE_W'(PLRU_W));
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                   input logic [WAY_W-1:0]  way);
    logic [NUM_WAYS-1:0] bits;
    logic [NODE_W-1:0]   node;
    logic [NODE_W-1:0]   parent;
    bits = {1'b0, tree};
    node = NODE_W'(way) + NODE_W'(PLRU_W);
    for (int l = 0; l < WAY_W; l++) begin
      parent = (node - NODE_W'(1)) >> 1;
      bits[parent[WAY_W-1:0]] = node[0];
      node = parent;
    end
    return bits[PLRU_W-1:0];
  endfunction

`ifdef BTB_DIR_CTR_EN
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction
`endif

  assign rd_set         = if_pc[IDX_W+1:2];
  assign rd_tag         = if_pc[31:IDX_W+2];
  assign wr_set         = ex_pc[IDX_W+1:2];
  assign wr_tag         = ex_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // Downward scans leave the lowest matching / lowest invalid way selected.
  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_set][w] && (tag_q[rd_set][w] == rd_tag)) begin
        rd_hit = 1'b1;
        rd_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    wr_hit    = 1'b0;
    wr_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[wr_set][w] && (tag_q[wr_set][w] == wr_tag)) begin
        wr_hit = 1'b1;
        wr_way = WAY_W'(w);
      end
      if (!valid_q[wr_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    alloc_way = inv_found ? inv_way : plru_victim(plru_q[wr_set]);
  end

  assign busy         = (state_q == ST_FLUSH);
  assign btb_hit      = rd_hit && !busy;
  assign predicted_pc = btb_hit ? tgt_q[rd_set][rd_way] : 32'h0;
`ifdef BTB_DIR_CTR_EN
  assign predict_taken = btb_hit && ctr_q[rd_set][rd_way][1];
`else
  assign predict_taken = btb_hit;
`endif

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    valid_d = valid_q;
    plru_d  = plru_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
`ifdef BTB_DIR_CTR_EN
    ctr_d   = ctr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
          sweep_d = '0;
        end else if (ex_update) begin
          if (wr_hit) begin
            if (ex_taken) begin
              tgt_d[wr_set][wr_way] = ex_target;
`ifdef BTB_DIR_CTR_EN
              ctr_d[wr_set][wr_way] = ctr_inc(ctr_q[wr_set][wr_way]);
`endif
              plru_d[wr_set] = plru_touch(plru_q[wr_set], wr_way);
            end else begin
`ifdef BTB_DIR_CTR_EN
              ctr_d[wr_set][wr_way] = ctr_dec(ctr_q[wr_set][wr_way]);
              plru_d[wr_set] = plru_touch(plru_q[wr_set], wr_way);
`else
              valid_d[wr_set][wr_way] = 1'b0;
`endif
            end
          end else if (ex_taken) begin
            valid_d[wr_set][alloc_way] = 1'b1;
            tag_d[wr_set][alloc_way]   = wr_tag;
            tgt_d[wr_set][alloc_way]   = ex_target;
`ifdef BTB_DIR_CTR_EN
            ctr_d[wr_set][alloc_way]   = 2'b10;
`endif
            plru_d[wr_set] = plru_touch(plru_q[wr_set], alloc_way);
          end
        end
      end
      ST_FLUSH: begin
        valid_d[sweep_q] = '0;
        plru_d[sweep_q]  = '0;
        sweep_d          = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(NUM_SETS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

  // Payload arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
`ifdef BTB_DIR_CTR_EN
    ctr_q <= ctr_d;
`endif
  end

endmodule

// File: tb/tb_btb_assoc_pred.sv
// tb_btb_assoc_pred: directed vector table, hand sequences for replacement/flush/reset,
// and randomized traffic checked against a behavioural BTB model.
module tb_btb_assoc_pred;

  localparam int NS = 16;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        btb_hit;
  logic        predict_taken;
  logic [31:0] predicted_pc;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        flush;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  btb_assoc_pred #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .btb_hit(btb_hit),
    .predict_taken(predict_taken), .predicted_pc(predicted_pc),
    .ex_update(ex_update), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] ifpc;
    logic        upd;
    logic [31:0] expc;
    logic [31:0] tgt;
    logic        eh;
    logic [31:0] epc;
  } vec_t;

  vec_t vt[6];

  // Behavioural model: entry arrays plus one pointer bit per halving of the way range.
  bit          m_valid [NS][NW];
  logic [31:0] m_tag   [NS][NW];
  logic [31:0] m_tgt   [NS][NW];
  int          m_ctr   [NS][NW];
  bit          m_dir   [NS][NW+1][NW];
  bit          m_busy;
  int          m_sweep;

  function automatic void m_reset();
    foreach (m_valid[s, w]) m_valid[s][w] = 0;
    foreach (m_dir[s, z, l]) m_dir[s][z][l] = 0;
    m_busy  = 0;
    m_sweep = 0;
  endfunction

  function automatic int m_victim(input int s);
    int lo = 0;
    int sz = NW;
    while (sz > 1) begin
      if (m_dir[s][sz][lo]) lo += sz / 2;
      sz = sz / 2;
    end
    return lo;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int lo = 0;
    int sz = NW;
    while (sz > 1) begin
      if (w < lo + sz / 2) m_dir[s][sz][lo] = 1;
      else begin
        m_dir[s][sz][lo] = 0;
        lo += sz / 2;
      end
      sz = sz / 2;
    end
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s = int'((pc >> 2) % NS);
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == (pc >> 6)) return w;
    return -1;
  endfunction

  function automatic void m_step(input logic upd, input logic [31:0] pc, input logic tk,
                                 input logic [31:0] tg, input logic fl);
    int s = int'((pc >> 2) % NS);
    int w;
    if (m_busy) begin
      for (int k = 0; k < NW; k++) m_valid[m_sweep][k] = 0;
      for (int z = 0; z <= NW; z++) for (int l = 0; l < NW; l++) m_dir[m_sweep][z][l] = 0;
      m_sweep++;
      if (m_sweep == NS) m_busy = 0;
    end else if (fl) begin
      m_busy  = 1;
      m_sweep = 0;
    end else if (upd) begin
      w = m_find(pc);
      if (w >= 0) begin
        if (tk) begin
          m_tgt[s][w] = tg;
          m_ctr[s][w] = (m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3;
          m_touch(s, w);
        end else begin
`ifdef BTB_DIR_CTR_EN
          m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
          m_touch(s, w);
`else
          m_valid[s][w] = 0;
`endif
        end
      end else if (tk) begin
        w = -1;
        for (int k = NW - 1; k >= 0; k--) if (!m_valid[s][k]) w = k;
        if (w < 0) w = m_victim(s);
        m_valid[s][w] = 1;
        m_tag[s][w]   = pc >> 6;
        m_tgt[s][w]   = tg;
        m_ctr[s][w]   = 2;
        m_touch(s, w);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ipc, input logic upd, input logic [31:0] epc,
                       input logic tk, input logic [31:0] tg, input logic fl);
    if_pc = ipc; ex_update = upd; ex_pc = epc; ex_taken = tk; ex_target = tg; flush = fl;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    drive(32'h0, 1'b1, pc, tk, tg, 1'b0);
    tick();
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic eh, input logic [31:0] epc);
    drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk({nm, "_hit"}, btb_hit, eh);
    chk({nm, "_pc"}, predicted_pc, eh ? epc : 32'h0);
    tick();
  endtask

  task automatic pulse_rst();
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] s = ($urandom_range(0, 1) != 0) ? 32'd3 : 32'd0;
    logic [31:0] t = 32'($urandom_range(0, 5));
    return (t << 6) | (s << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int          n;
    bit          swept_hit;
    logic [31:0] r_if, r_ep, r_tg;
    logic        r_upd, r_tk, r_fl;
    int          mw, ms;
    logic        e_hit, e_pt;
    logic [31:0] e_pc;

    vt[0] = '{32'h100, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0};
    vt[1] = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0};
    vt[2] = '{32'h100, 1'b0, 32'h0,   32'h0,   1'b1, 32'h200};
    vt[3] = '{32'h140, 1'b1, 32'h140, 32'h444, 1'b0, 32'h0};
    vt[4] = '{32'h141, 1'b0, 32'h0,   32'h0,   1'b1, 32'h444};
    vt[5] = '{32'h103, 1'b0, 32'h0,   32'h0,   1'b1, 32'h200};

    rst = 1'b1; if_pc = 0; ex_update = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; flush = 0;
    #12 rst = 1'b0;
    tick();

    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_pt", predict_taken, 1'b0);

    for (int i = 0; i < 6; i++) begin
      drive(vt[i].ifpc, vt[i].upd, vt[i].expc, 1'b1, vt[i].tgt, 1'b0);
      chk($sformatf("vec%0d_hit", i), btb_hit, vt[i].eh);
      chk($sformatf("vec%0d_pt", i), predict_taken, vt[i].eh);
      chk($sformatf("vec%0d_pc", i), predicted_pc, vt[i].epc);
      tick();
    end

    pulse_rst();
    upd(32'h000, 1'b1, 32'h1000);
    upd(32'h040, 1'b1, 32'h1040);
    upd(32'h080, 1'b1, 32'h1080);
    upd(32'h0C0, 1'b1, 32'h10C0);
    upd(32'h000, 1'b1, 32'h1000);
    upd(32'h100, 1'b1, 32'h1100);
    look("rep_000", 32'h000, 1'b1, 32'h1000);
    look("rep_040", 32'h040, 1'b1, 32'h1040);
    look("rep_0c0", 32'h0C0, 1'b1, 32'h10C0);
    look("rep_080", 32'h080, 1'b0, 32'h0);
    look("rep_100", 32'h100, 1'b1, 32'h1100);

    upd(32'h040, 1'b1, 32'h999);
    look("dup_040", 32'h040, 1'b1, 32'h999);
    look("dup_0c0", 32'h0C0, 1'b1, 32'h10C0);
    upd(32'h140, 1'b1, 32'h1140);
    look("rep2_140", 32'h140, 1'b1, 32'h1140);
    look("rep2_0c0", 32'h0C0, 1'b0, 32'h0);

    upd(32'h004, 1'b1, 32'h5004);
    upd(32'h014, 1'b1, 32'h5014);
    drive(32'h000, 1'b1, 32'h024, 1'b1, 32'h5024, 1'b1);
    chk("flush_start_hit", btb_hit, 1'b1);
    chk("flush_start_busy", busy, 1'b0);
    tick();
    n = 0;
    swept_hit = 0;
    while (n < 40) begin
      drive(32'h000, n == 3, 32'h028, 1'b1, 32'h5028, n == 5);
      if (!busy) break;
      if (btb_hit || predict_taken || predicted_pc != 0) swept_hit = 1;
      n++;
      tick();
    end
    chk("flush_len", n, 16);
    chk("flush_outputs_zero", swept_hit, 1'b0);
    tick();
    look("post_000", 32'h000, 1'b0, 32'h0);
    look("post_040", 32'h040, 1'b0, 32'h0);
    look("post_140", 32'h140, 1'b0, 32'h0);
    look("post_004", 32'h004, 1'b0, 32'h0);
    look("post_014", 32'h014, 1'b0, 32'h0);
    look("post_024", 32'h024, 1'b0, 32'h0);
    look("post_028", 32'h028, 1'b0, 32'h0);

    upd(32'h004, 1'b1, 32'h7004);
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    repeat (5) begin
      drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(32'h004, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("midsweep_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_hit", btb_hit, 1'b0);
    rst = 1'b0;
    tick();
    look("rst_mid_004", 32'h004, 1'b0, 32'h0);

`ifdef BTB_DIR_CTR_EN
    upd(32'h300, 1'b1, 32'h3300);
    upd(32'h300, 1'b0, 32'h0);
    upd(32'h300, 1'b0, 32'h0);
    drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("ctr_nt_hit", btb_hit, 1'b1);
    chk("ctr_nt_pt", predict_taken, 1'b0);
    tick();
    repeat (3) upd(32'h300, 1'b1, 32'h3300);
    drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("ctr_t_pt", predict_taken, 1'b1);
    tick();
    upd(32'h300, 1'b1, 32'h3300);
    upd(32'h300, 1'b0, 32'h0);
    drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("ctr_sat_pt", predict_taken, 1'b1);
    tick();
`else
    upd(32'h300, 1'b1, 32'h3300);
    look("nt_before", 32'h300, 1'b1, 32'h3300);
    upd(32'h300, 1'b0, 32'h0);
    look("nt_clears", 32'h300, 1'b0, 32'h0);
`endif

    pulse_rst();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      r_if  = rnd_pc();
      r_upd = 1'($urandom_range(0, 1));
      r_ep  = rnd_pc();
      r_tk  = ($urandom_range(0, 9) < 7);
      r_tg  = $urandom;
      r_fl  = ($urandom_range(0, 99) == 0);
      drive(r_if, r_upd, r_ep, r_tk, r_tg, r_fl);
      mw = m_find(r_if);
      ms = int'((r_if >> 2) % NS);
      e_hit = !m_busy && (mw >= 0);
      e_pc  = e_hit ? m_tgt[ms][mw] : 32'h0;
`ifdef BTB_DIR_CTR_EN
      e_pt  = e_hit && (m_ctr[ms][mw] >= 2);
`else
      e_pt  = e_hit;
`endif
      chk($sformatf("rnd%0d_hit", c), btb_hit, e_hit);
      chk($sformatf("rnd%0d_pt", c), predict_taken, e_pt);
      chk($sformatf("rnd%0d_pc", c), predicted_pc, e_pc);
      chk($sformatf("rnd%0d_busy", c), busy, m_busy);
      @(posedge clk);
      m_step(r_upd, r_ep, r_tk, r_tg, r_fl);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
